store_watch: RTL and testbench

STORE_WATCH -- requirements
Module: store_watch

---
 rtl/store_watch_if.sv | 22 ++
 rtl/store_watch.sv | 122 ++++++++++++
 tb/tb_store_watch.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/store_watch_if.sv
// Store bus and report stream shared between the CPU/consumer side and store_watch.
// The master drives stores and out_ready. The slave (store_watch) returns the report stream.
interface store_watch_if;
  logic [2:0]  MemWr;
  logic [15:0] Addr;
  logic [31:0] WData;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_idx;
  logic [31:0] out_data;
  logic        overflow;

  modport master (
    output MemWr, Addr, WData, out_ready,
    input  out_valid, out_idx, out_data, overflow
  );

  modport slave (
    input  MemWr, Addr, WData, out_ready,
    output out_valid, out_idx, out_data, overflow
  );
endinterface

// File: rtl/store_watch.sv
// Shadows four big-endian memory words and reports every store that changes one.
// Each changing store queues an {index, new value} entry in a small report FIFO.
module store_watch #(
  parameter logic [15:0] BASE       = 16'hffe8,
  parameter int          FIFO_DEPTH = 4
) (
  input logic         Clk,
  input logic         Reset,
  store_watch_if.slave bus
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  // Byte-enable mask for the addressed lanes; lane 0 is the most significant byte.
  function automatic logic [31:0] lane_mask(input logic [2:0] wr, input logic [1:0] lane);
    logic [31:0] m;
    m = '0;
    case (wr)
      3'b001:  m = 32'hFFFF_FFFF;
      3'b010:  m = lane[1] ? 32'h0000_FFFF : 32'hFFFF_0000;
      3'b100:  m = 32'hFF00_0000 >> {lane, 3'b000};
      default: m = '0;
    endcase
    return m;
  endfunction

  // Store data replicated across every lane so the mask alone selects placement.
  function automatic logic [31:0] lane_data(input logic [2:0] wr, input logic [31:0] wdata);
    logic [31:0] d;
    d = '0;
    case (wr)
      3'b001:  d = wdata;
      3'b010:  d = {2{wdata[15:0]}};
      3'b100:  d = {4{wdata[7:0]}};
      default: d = '0;
    endcase
    return d;
  endfunction

  logic [31:0]   shadow [4];
  logic [1:0]    fifo_idx  [FIFO_DEPTH];
  logic [31:0]   fifo_data [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          overflow_q;

  logic [16:0] offset;
  logic        in_win;
  logic [1:0]  idx;
  logic [1:0]  lane;
  logic        hit;
  logic [31:0] mask;
  logic [31:0] merged;
  logic        changed;
  logic        full;
  logic        not_empty;
  logic        pop;
  logic        do_push;

  // Decode and merge stage: the window check uses a 17-bit difference so addresses below BASE fall out.
  assign offset = {1'b0, bus.Addr} - {1'b0, BASE};
  assign in_win = (offset[16:4] == 13'd0);
  assign idx    = offset[3:2];
  assign lane   = offset[1:0];

  always_comb begin
    hit = 1'b0;
    case (bus.MemWr)
      3'b001:  hit = in_win && (lane == 2'd0);
      3'b010:  hit = in_win && !lane[0];
      3'b100:  hit = in_win;
      default: hit = 1'b0;
    endcase
  end

  assign mask    = lane_mask(bus.MemWr, lane);
  assign merged  = (shadow[idx] & ~mask) | (lane_data(bus.MemWr, bus.WData) & mask);
  assign changed = hit && (merged != shadow[idx]);

  assign not_empty = (count != '0);
  assign full      = (count == FULL_CNT);
  assign pop       = not_empty && bus.out_ready;
  assign do_push   = changed && (!full || pop);

  // Shadow and FIFO control state update.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 4; i++) shadow[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (changed) shadow[idx] <= merged;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (changed && full && !pop) overflow_q <= 1'b1;
    end
  end

  // FIFO storage is not reset; empty-state outputs are forced to zero below.
  always_ff @(posedge Clk) begin
    if (do_push && !Reset) begin
      fifo_idx[wr_ptr]  <= idx;
      fifo_data[wr_ptr] <= merged;
    end
  end

  // Output stage: registered FIFO head, masked to zero when empty.
  assign bus.out_valid = not_empty;
  assign bus.out_idx   = not_empty ? fifo_idx[rd_ptr]  : 2'd0;
  assign bus.out_data  = not_empty ? fifo_data[rd_ptr] : 32'd0;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_store_watch.sv
// Self-checking bench for store_watch: directed vector table, hand sequences and
// randomized stores compared against a byte-level reference model.
module tb_store_watch;

  localparam logic [15:0] BASE  = 16'hffe8;
  localparam int          DEPTH = 4;

  logic Clk;
  logic Reset;
  store_watch_if bus ();

  store_watch #(.BASE(BASE), .FIFO_DEPTH(DEPTH)) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks;
  int failures;

  typedef struct {
    logic [1:0]  idx;
    logic [31:0] data;
  } ent_t;

  logic [31:0] m_sh [4];
  ent_t        m_q [$];
  logic        m_ovf;

  typedef struct {
    string       name;
    logic        rst;
    logic [2:0]  wr;
    logic [15:0] addr;
    logic [31:0] wd;
    logic        rdy;
    logic        ev;
    logic [1:0]  ei;
    logic [31:0] ed;
    logic        eo;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: memory as bytes, report queue as a plain bounded queue.
  task automatic model_edge(input logic r, input logic [2:0] wr, input logic [15:0] a,
                            input logic [31:0] d, input logic rdy);
    int off, ix, ln, nb;
    logic [7:0]  b [4];
    logic [31:0] nv;
    ent_t e;
    if (r) begin
      for (int i = 0; i < 4; i++) m_sh[i] = '0;
      m_q.delete();
      m_ovf = 1'b0;
      return;
    end
    off = int'(a) - int'(BASE);
    nb  = 0;
    ix  = 0;
    ln  = 0;
    if (off >= 0 && off < 16) begin
      ix = off / 4;
      ln = off % 4;
      if (wr == 3'b001 && ln == 0) nb = 4;
      else if (wr == 3'b010 && (ln % 2) == 0) nb = 2;
      else if (wr == 3'b100) nb = 1;
    end
    if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
    if (nb > 0) begin
      for (int k = 0; k < 4; k++) b[k] = m_sh[ix][31-8*k -: 8];
      for (int j = 0; j < nb; j++) b[ln+j] = d[8*(nb-1-j) +: 8];
      nv = {b[0], b[1], b[2], b[3]};
      if (nv != m_sh[ix]) begin
        m_sh[ix] = nv;
        if (m_q.size() < DEPTH) begin
          e.idx  = 2'(ix);
          e.data = nv;
          m_q.push_back(e);
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic drive(input logic r, input logic [2:0] wr, input logic [15:0] a,
                       input logic [31:0] d, input logic rdy);
    @(negedge Clk);
    Reset         = r;
    bus.MemWr     = wr;
    bus.Addr      = a;
    bus.WData     = d;
    bus.out_ready = rdy;
    @(posedge Clk);
    model_edge(r, wr, a, d, rdy);
    #1;
  endtask

  task automatic expect_out(input string nm, input logic ev, input logic [1:0] ei,
                            input logic [31:0] ed, input logic eo);
    chk({nm, ".valid"}, 32'(bus.out_valid), 32'(ev));
    chk({nm, ".idx"},   32'(bus.out_idx),   32'(ei));
    chk({nm, ".data"},  bus.out_data,       ed);
    chk({nm, ".ovf"},   32'(bus.overflow),  32'(eo));
  endtask

  task automatic step(input string nm, input logic r, input logic [2:0] wr, input logic [15:0] a,
                      input logic [31:0] d, input logic rdy, input logic ev, input logic [1:0] ei,
                      input logic [31:0] ed, input logic eo);
    drive(r, wr, a, d, rdy);
    expect_out(nm, ev, ei, ed, eo);
  endtask

  function automatic void add(input string nm, input logic r, input logic [2:0] wr,
                              input logic [15:0] a, input logic [31:0] d, input logic rdy,
                              input logic ev, input logic [1:0] ei, input logic [31:0] ed,
                              input logic eo);
    vec_t v;
    v.name = nm; v.rst = r; v.wr = wr; v.addr = a; v.wd = d; v.rdy = rdy;
    v.ev = ev; v.ei = ei; v.ed = ed; v.eo = eo;
    tbl.push_back(v);
  endfunction

  initial begin
    checks        = 0;
    failures      = 0;
    Reset         = 1'b1;
    bus.MemWr     = 3'b000;
    bus.Addr      = 16'h0000;
    bus.WData     = 32'h0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) m_sh[i] = '0;
    m_ovf = 1'b0;

    //          name         rst wr      addr      data          rdy ev ei  ed             eo
    add("reset",      1, 3'b000, 16'h0000, 32'h0,         0, 0, 0, 32'h0,         0);
    add("w7",         0, 3'b001, 16'hffec, 32'h0000_0007, 0, 1, 1, 32'h0000_0007, 0);
    add("pop7",       0, 3'b000, 16'h0000, 32'h0,         1, 0, 0, 32'h0,         0);
    add("w7_same",    0, 3'b001, 16'hffec, 32'h0000_0007, 0, 0, 0, 32'h0,         0);
    add("bAB",        0, 3'b100, 16'hfff1, 32'h0000_00AB, 0, 1, 2, 32'h00AB_0000, 0);
    add("h1234",      0, 3'b010, 16'hfff2, 32'h0000_1234, 0, 1, 2, 32'h00AB_0000, 0);
    add("popAB",      0, 3'b000, 16'h0000, 32'h0,         1, 1, 2, 32'h00AB_1234, 0);
    add("pop1234",    0, 3'b000, 16'h0000, 32'h0,         1, 0, 0, 32'h0,         0);
    add("h_misalgn",  0, 3'b010, 16'hffe9, 32'hFFFF_FFFF, 0, 0, 0, 32'h0,         0);
    add("w_misalgn",  0, 3'b001, 16'hffea, 32'hFFFF_FFFF, 0, 0, 0, 32'h0,         0);
    add("w_outside",  0, 3'b001, 16'hfff8, 32'hFFFF_FFFF, 0, 0, 0, 32'h0,         0);
    add("w_below",    0, 3'b001, 16'hffe4, 32'hFFFF_FFFF, 0, 0, 0, 32'h0,         0);
    add("not_onehot", 0, 3'b011, 16'hffe8, 32'hFFFF_FFFF, 0, 0, 0, 32'h0,         0);
    add("sh0_kept",   0, 3'b001, 16'hffe8, 32'h0,         0, 0, 0, 32'h0,         0);
    add("sh1_kept",   0, 3'b001, 16'hffec, 32'h0000_0007, 0, 0, 0, 32'h0,         0);
    add("sh2_kept",   0, 3'b010, 16'hfff0, 32'h0000_00AB, 0, 0, 0, 32'h0,         0);
    add("fill1",      0, 3'b001, 16'hffe8, 32'd1,         0, 1, 0, 32'd1,         0);
    add("fill2",      0, 3'b001, 16'hffe8, 32'd2,         0, 1, 0, 32'd1,         0);
    add("fill3",      0, 3'b001, 16'hffe8, 32'd3,         0, 1, 0, 32'd1,         0);
    add("fill4",      0, 3'b001, 16'hffe8, 32'd4,         0, 1, 0, 32'd1,         0);
    add("drop5",      0, 3'b001, 16'hffe8, 32'd5,         0, 1, 0, 32'd1,         1);
    add("drain1",     0, 3'b000, 16'h0000, 32'h0,         1, 1, 0, 32'd2,         1);
    add("drain2",     0, 3'b000, 16'h0000, 32'h0,         1, 1, 0, 32'd3,         1);
    add("drain3",     0, 3'b000, 16'h0000, 32'h0,         1, 1, 0, 32'd4,         1);
    add("drain4",     0, 3'b000, 16'h0000, 32'h0,         1, 0, 0, 32'h0,         1);
    add("sh0_is5",    0, 3'b001, 16'hffe8, 32'd5,         0, 0, 0, 32'h0,         1);

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].name, tbl[i].rst, tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].rdy,
           tbl[i].ev, tbl[i].ei, tbl[i].ed, tbl[i].eo);

    // Full FIFO with simultaneous push and pop keeps occupancy and sets no overflow.
    step("r2",     1, 3'b000, 16'h0000, 32'h0,  0, 0, 0, 32'h0,  0);
    step("f10",    0, 3'b001, 16'hfff0, 32'd10, 0, 1, 2, 32'd10, 0);
    step("f11",    0, 3'b001, 16'hfff0, 32'd11, 0, 1, 2, 32'd10, 0);
    step("f12",    0, 3'b001, 16'hfff0, 32'd12, 0, 1, 2, 32'd10, 0);
    step("f13",    0, 3'b001, 16'hfff0, 32'd13, 0, 1, 2, 32'd10, 0);
    step("pp14",   0, 3'b001, 16'hfff0, 32'd14, 1, 1, 2, 32'd11, 0);
    step("d12",    0, 3'b000, 16'h0000, 32'h0,  1, 1, 2, 32'd12, 0);
    step("d13",    0, 3'b000, 16'h0000, 32'h0,  1, 1, 2, 32'd13, 0);
    step("d14",    0, 3'b000, 16'h0000, 32'h0,  1, 1, 2, 32'd14, 0);
    step("dempty", 0, 3'b000, 16'h0000, 32'h0,  1, 0, 0, 32'h0,  0);

    // Reset mid-drain wins over a concurrent store and pop; first store afterwards is live.
    for (int k = 1; k <= 5; k++)
      step("ofill", 0, 3'b001, 16'hffe8, 32'(k), 0, 1, 0, 32'd1, (k == 5));
    step("odrain", 0, 3'b000, 16'h0000, 32'h0,         1, 1, 0, 32'd2,         1);
    step("rmid",   1, 3'b001, 16'hffe8, 32'd9,         1, 0, 0, 32'h0,         0);
    step("post_r", 0, 3'b001, 16'hffec, 32'h0000_0007, 0, 1, 1, 32'h0000_0007, 0);
    step("post_2", 0, 3'b001, 16'hffe8, 32'd9,         0, 1, 1, 32'h0000_0007, 0);

    // Randomized traffic around the window against the reference model.
    for (int n = 0; n < 1500; n++) begin
      logic [2:0]  wr;
      logic [31:0] d;
      int          p;
      logic        r;
      p = $urandom_range(0, 9);
      case (p)
        0, 1:    wr = 3'b000;
        2, 3, 4: wr = 3'b001;
        5, 6:    wr = 3'b010;
        7, 8:    wr = 3'b100;
        default: wr = ($urandom_range(0, 1) == 0) ? 3'b011 : 3'b110;
      endcase
      d = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      r = ($urandom_range(0, 249) == 0);
      drive(r, wr, 16'(int'(BASE) - 4 + $urandom_range(0, 23)), d, ($urandom_range(0, 2) == 0));
      if (m_q.size() > 0)
        expect_out("rand", 1'b1, m_q[0].idx, m_q[0].data, m_ovf);
      else
        expect_out("rand", 1'b0, 2'd0, 32'h0, m_ovf);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
